// File: rtl/rs_add.sv
// Reservation station for the ADD unit: holds dispatched ops, captures operands from two
// result broadcast buses, and issues the lowest-index op whose operands are both ready.
module rs_add #(
    parameter int DEPTH = 4,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze_back,
    input  logic        valid_dispatch,
    input  logic [4:0]  Pw_dispatch,
    input  logic [4:0]  tag_ROB_dispatch,
    input  logic [4:0]  Pa_dispatch,
    input  logic [4:0]  Pb_dispatch,
    input  logic        rdyA_dispatch,
    input  logic        rdyB_dispatch,
    input  logic [15:0] dataA_dispatch,
    input  logic [15:0] dataB_dispatch,
    output logic        full_rs,
    input  logic        valid_Result_add,
    input  logic [4:0]  Pw_Result_add,
    input  logic [15:0] Result_add,
    input  logic        valid_Result_oth,
    input  logic [4:0]  Pw_Result_oth,
    input  logic [15:0] Result_oth,
    output logic        valid_add,
    output logic [4:0]  Pw_add,
    output logic [4:0]  tag_ROB_add,
    output logic [15:0] busA_add,
    output logic [15:0] busB_add
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rdya_q, rdya_d;
    logic [DEPTH-1:0] rdyb_q, rdyb_d;
    logic [4:0]       pw_q   [DEPTH];
    logic [4:0]       pw_d   [DEPTH];
    logic [4:0]       tag_q  [DEPTH];
    logic [4:0]       tag_d  [DEPTH];
    logic [4:0]       pa_q   [DEPTH];
    logic [4:0]       pa_d   [DEPTH];
    logic [4:0]       pb_q   [DEPTH];
    logic [4:0]       pb_d   [DEPTH];
    logic [15:0]      vala_q [DEPTH];
    logic [15:0]      vala_d [DEPTH];
    logic [15:0]      valb_q [DEPTH];
    logic [15:0]      valb_d [DEPTH];

    logic             valid_add_q;
    logic [4:0]       pw_add_q;
    logic [4:0]       tag_add_q;
    logic [15:0]      busa_q;
    logic [15:0]      busb_q;

    logic [DEPTH-1:0] elig;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    free_idx;
    logic             any_elig;
    logic             issue_fire;
    logic             dispatch_fire;

    // Returns {ready, value}; bus 0 has priority, a ready source is never overwritten.
    function automatic logic [16:0] wake(input logic [4:0] p, input logic rdy,
                                         input logic [15:0] val);
        logic [16:0] r;
        r = {rdy, val};
        if (!rdy) begin
            if (valid_Result_add && (Pw_Result_add == p)) begin
                r = {1'b1, Result_add};
            end else if (valid_Result_oth && (Pw_Result_oth == p)) begin
                r = {1'b1, Result_oth};
            end
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
        assign elig[gi] = valid_q[gi] & rdya_q[gi] & rdyb_q[gi];
    end

    assign full_rs = &valid_q;

    always_comb begin
        win_idx  = '0;
        free_idx = '0;
        any_elig = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx  = IW'(i);
                any_elig = 1'b1;
            end
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign issue_fire    = any_elig && !flush && !freeze_back;
    assign dispatch_fire = valid_dispatch && !full_rs && !flush;

    always_comb begin
        valid_d = valid_q;
        rdya_d  = rdya_q;
        rdyb_d  = rdyb_q;
        pw_d    = pw_q;
        tag_d   = tag_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        vala_d  = vala_q;
        valb_d  = valb_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (dispatch_fire && (free_idx == IW'(i))) begin
                valid_d[i] = 1'b1;
                pw_d[i]    = Pw_dispatch;
                tag_d[i]   = tag_ROB_dispatch;
                pa_d[i]    = Pa_dispatch;
                pb_d[i]    = Pb_dispatch;
                {rdya_d[i], vala_d[i]} = wake(Pa_dispatch, rdyA_dispatch, dataA_dispatch);
                {rdyb_d[i], valb_d[i]} = wake(Pb_dispatch, rdyB_dispatch, dataB_dispatch);
            end else if (valid_q[i]) begin
                {rdya_d[i], vala_d[i]} = wake(pa_q[i], rdya_q[i], vala_q[i]);
                {rdyb_d[i], valb_d[i]} = wake(pb_q[i], rdyb_q[i], valb_q[i]);
                if (issue_fire && (win_idx == IW'(i))) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rdya_q  <= '0;
            rdyb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pw_q[i]   <= '0;
                tag_q[i]  <= '0;
                pa_q[i]   <= '0;
                pb_q[i]   <= '0;
                vala_q[i] <= '0;
                valb_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdya_q  <= rdya_d;
            rdyb_q  <= rdyb_d;
            pw_q    <= pw_d;
            tag_q   <= tag_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
        end
    end

    // Issue register: flush clears, freeze holds, an idle cycle drops only the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_add_q <= 1'b0;
            pw_add_q    <= '0;
            tag_add_q   <= '0;
            busa_q      <= '0;
            busb_q      <= '0;
        end else if (flush) begin
            valid_add_q <= 1'b0;
            pw_add_q    <= '0;
            tag_add_q   <= '0;
            busa_q      <= '0;
            busb_q      <= '0;
        end else if (!freeze_back) begin
            if (any_elig) begin
                valid_add_q <= 1'b1;
                pw_add_q    <= pw_q[win_idx];
                tag_add_q   <= tag_q[win_idx];
                busa_q      <= vala_q[win_idx];
                busb_q      <= valb_q[win_idx];
            end else begin
                valid_add_q <= 1'b0;
            end
        end
    end

    assign valid_add   = valid_add_q;
    assign Pw_add      = pw_add_q;
    assign tag_ROB_add = tag_add_q;
    assign busA_add    = busa_q;
    assign busB_add    = busb_q;

endmodule

// File: tb/tb_rs_add.sv
// Bench for rs_add: a cycle-level reference model predicts the issue outputs after every
// edge into a queue; a negedge monitor pops and compares. Directed cases plus random traffic.
module tb_rs_add;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, freeze_back = 1'b0, valid_dispatch = 1'b0;
    logic [4:0]  Pw_dispatch = '0, tag_ROB_dispatch = '0, Pa_dispatch = '0, Pb_dispatch = '0;
    logic        rdyA_dispatch = 1'b0, rdyB_dispatch = 1'b0;
    logic [15:0] dataA_dispatch = '0, dataB_dispatch = '0;
    logic        valid_Result_add = 1'b0, valid_Result_oth = 1'b0;
    logic [4:0]  Pw_Result_add = '0, Pw_Result_oth = '0;
    logic [15:0] Result_add = '0, Result_oth = '0;
    logic        full_rs, valid_add;
    logic [4:0]  Pw_add, tag_ROB_add;
    logic [15:0] busA_add, busB_add;

    rs_add #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .valid_dispatch(valid_dispatch), .Pw_dispatch(Pw_dispatch),
        .tag_ROB_dispatch(tag_ROB_dispatch), .Pa_dispatch(Pa_dispatch),
        .Pb_dispatch(Pb_dispatch), .rdyA_dispatch(rdyA_dispatch),
        .rdyB_dispatch(rdyB_dispatch), .dataA_dispatch(dataA_dispatch),
        .dataB_dispatch(dataB_dispatch), .full_rs(full_rs),
        .valid_Result_add(valid_Result_add), .Pw_Result_add(Pw_Result_add),
        .Result_add(Result_add), .valid_Result_oth(valid_Result_oth),
        .Pw_Result_oth(Pw_Result_oth), .Result_oth(Result_oth),
        .valid_add(valid_add), .Pw_add(Pw_add), .tag_ROB_add(tag_ROB_add),
        .busA_add(busA_add), .busB_add(busB_add)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v; bit [4:0] pw; bit [4:0] tag; bit [4:0] pa; bit [4:0] pb;
        bit ra; bit rb; bit [15:0] va; bit [15:0] vb;
    } ent_t;
    typedef struct {
        bit v; bit [4:0] pw; bit [4:0] tag; bit [15:0] a; bit [15:0] b; bit full;
    } snap_t;

    ent_t  m [DEPTH];
    snap_t out_m;
    snap_t sbq [$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    // Operand as seen after this cycle's broadcasts: bus 0 first, then bus 1.
    function automatic bit [16:0] resolve(input bit [4:0] p, input bit rdy, input bit [15:0] val);
        if (rdy) return {1'b1, val};
        if (valid_Result_add && Pw_Result_add == p) return {1'b1, Result_add};
        if (valid_Result_oth && Pw_Result_oth == p) return {1'b1, Result_oth};
        return {1'b0, val};
    endfunction

    task automatic model_step();
        ent_t nxt [DEPTH];
        int   win = -1;
        int   fr = -1;
        bit   was_full = 1'b1;
        foreach (m[i]) if (!m[i].v) was_full = 1'b0;
        if (flush) begin
            foreach (m[i]) m[i].v = 1'b0;
            out_m = '{default: 0};
        end else begin
            foreach (m[i]) begin
                if (win < 0 && m[i].v && m[i].ra && m[i].rb) win = i;
                if (fr < 0 && !m[i].v) fr = i;
            end
            nxt = m;
            foreach (nxt[i]) if (nxt[i].v) begin
                {nxt[i].ra, nxt[i].va} = resolve(m[i].pa, m[i].ra, m[i].va);
                {nxt[i].rb, nxt[i].vb} = resolve(m[i].pb, m[i].rb, m[i].vb);
            end
            if (!freeze_back) begin
                if (win >= 0) begin
                    out_m.v = 1'b1; out_m.pw = m[win].pw; out_m.tag = m[win].tag;
                    out_m.a = m[win].va; out_m.b = m[win].vb;
                    nxt[win].v = 1'b0;
                end else begin
                    out_m.v = 1'b0;
                end
            end
            if (valid_dispatch && !was_full) begin
                nxt[fr].v = 1'b1; nxt[fr].pw = Pw_dispatch; nxt[fr].tag = tag_ROB_dispatch;
                nxt[fr].pa = Pa_dispatch; nxt[fr].pb = Pb_dispatch;
                {nxt[fr].ra, nxt[fr].va} = resolve(Pa_dispatch, rdyA_dispatch, dataA_dispatch);
                {nxt[fr].rb, nxt[fr].vb} = resolve(Pb_dispatch, rdyB_dispatch, dataB_dispatch);
            end
            m = nxt;
        end
        out_m.full = 1'b1;
        foreach (m[i]) if (!m[i].v) out_m.full = 1'b0;
        sbq.push_back(out_m);
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (!rst && sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (valid_add !== e.v || Pw_add !== e.pw || tag_ROB_add !== e.tag ||
                busA_add !== e.a || busB_add !== e.b || full_rs !== e.full) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d: got v=%0d pw=%0d tag=%0d a=%h b=%h full=%0d, expected v=%0d pw=%0d tag=%0d a=%h b=%h full=%0d",
                         cyc, valid_add, Pw_add, tag_ROB_add, busA_add, busB_add, full_rs,
                         e.v, e.pw, e.tag, e.a, e.b, e.full);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        valid_dispatch = 0; flush = 0; freeze_back = 0;
        valid_Result_add = 0; valid_Result_oth = 0;
    endtask

    task automatic set_disp(input logic [4:0] pw, input logic [4:0] tag, input logic [4:0] pa,
                            input logic [4:0] pb, input logic ra, input logic rb,
                            input logic [15:0] a, input logic [15:0] b);
        valid_dispatch = 1; Pw_dispatch = pw; tag_ROB_dispatch = tag; Pa_dispatch = pa;
        Pb_dispatch = pb; rdyA_dispatch = ra; rdyB_dispatch = rb;
        dataA_dispatch = a; dataB_dispatch = b;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, valid_add, 0);
        chk({name, "_pw"}, Pw_add, 0);
        chk({name, "_tag"}, tag_ROB_add, 0);
        chk({name, "_busA"}, busA_add, 0);
        chk({name, "_busB"}, busB_add, 0);
        chk({name, "_full"}, full_rs, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1;
        #1 chk_reset_outputs("midreset");
        foreach (m[i]) m[i].v = 1'b0;
        out_m = '{default: 0};
        idle();
        #1 rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 chk_reset_outputs("reset");
        @(negedge clk);
        #3 rst = 0;

        // ready op issues one edge after dispatch, then goes idle
        set_disp(3, 1, 0, 0, 1, 1, 16'h0010, 16'h0020); tick();
        idle(); tick();
        chk("rdy_valid", valid_add, 1); chk("rdy_pw", Pw_add, 3); chk("rdy_tag", tag_ROB_add, 1);
        chk("rdy_busA", busA_add, 16'h0010); chk("rdy_busB", busB_add, 16'h0020);
        tick();
        chk("rdy_after", valid_add, 0);

        // wakeup through bus 1
        set_disp(9, 2, 7, 1, 0, 1, 16'h0000, 16'h0005); tick();
        idle(); tick(); tick();
        chk("wake_wait", valid_add, 0);
        valid_Result_oth = 1; Pw_Result_oth = 7; Result_oth = 16'h1234; tick();
        idle();
        chk("wake_not_early", valid_add, 0);
        tick();
        chk("wake_valid", valid_add, 1); chk("wake_busA", busA_add, 16'h1234);
        tick();

        // dispatch bypass, both buses matching: bus 0 wins
        set_disp(4, 3, 5, 1, 0, 1, 16'h0000, 16'h0007);
        valid_Result_add = 1; Pw_Result_add = 5; Result_add = 16'hAAAA;
        valid_Result_oth = 1; Pw_Result_oth = 5; Result_oth = 16'hBBBB;
        tick();
        idle(); tick();
        chk("byp_valid", valid_add, 1); chk("byp_busA", busA_add, 16'hAAAA);
        tick();

        // fill, drop a fifth (ready) dispatch, free entry 2 and refill it
        for (int k = 0; k < 4; k++) begin
            set_disp(5'(10 + k), 5'(4 + k), 5'(10 + k), 1, 0, 1, 16'h0, 16'(k)); tick();
        end
        chk("full_set", full_rs, 1);
        set_disp(15, 8, 16, 17, 1, 1, 16'hDEAD, 16'hBEEF); tick();
        idle();
        chk("full_drop", full_rs, 1);
        valid_Result_add = 1; Pw_Result_add = 12; Result_add = 16'h0C0C; tick();
        idle(); tick();
        chk("full_issue_tag", tag_ROB_add, 6); chk("full_cleared", full_rs, 0);
        set_disp(16, 9, 20, 1, 0, 1, 16'h0, 16'h0009); tick();
        idle();
        chk("full_refill", full_rs, 1);
        valid_Result_add = 1; Pw_Result_add = 10; Result_add = 16'h0A0A;
        valid_Result_oth = 1; Pw_Result_oth = 20; Result_oth = 16'h1414; tick();
        idle(); tick();
        chk("order_first", tag_ROB_add, 4);
        tick();
        chk("order_second", tag_ROB_add, 9); chk("order_second_busA", busA_add, 16'h1414);
        flush = 1; tick();
        idle();
        chk("flush_empty", full_rs, 0);

        // freeze holds issue outputs, dispatch still accepted
        set_disp(1, 10, 0, 0, 1, 1, 16'h1111, 16'h2222); tick();
        idle(); tick();
        chk("frz_first", tag_ROB_add, 10);
        set_disp(2, 11, 0, 0, 1, 1, 16'h3333, 16'h4444); freeze_back = 1; tick();
        idle(); freeze_back = 1; tick(); tick();
        chk("frz_hold_valid", valid_add, 1); chk("frz_hold_tag", tag_ROB_add, 10);
        freeze_back = 0; tick();
        chk("frz_release_tag", tag_ROB_add, 11); chk("frz_release_busA", busA_add, 16'h3333);
        tick();

        // flush beats freeze
        set_disp(5, 12, 0, 0, 1, 1, 16'h5555, 16'h6666); tick();
        idle(); flush = 1; freeze_back = 1; tick();
        idle();
        chk("flfr_valid", valid_add, 0); chk("flfr_pw", Pw_add, 0); chk("flfr_busA", busA_add, 0);
        tick();
        chk("flfr_no_issue", valid_add, 0);

        // random traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            valid_dispatch   = ($urandom_range(0, 99) < 55);
            Pw_dispatch      = 5'($urandom);
            tag_ROB_dispatch = 5'($urandom);
            Pa_dispatch      = 5'($urandom_range(0, 7));
            Pb_dispatch      = 5'($urandom_range(0, 7));
            rdyA_dispatch    = ($urandom_range(0, 2) == 0);
            rdyB_dispatch    = ($urandom_range(0, 2) == 0);
            dataA_dispatch   = 16'($urandom);
            dataB_dispatch   = 16'($urandom);
            valid_Result_add = ($urandom_range(0, 99) < 40);
            Pw_Result_add    = 5'($urandom_range(0, 7));
            Result_add       = 16'($urandom);
            valid_Result_oth = ($urandom_range(0, 99) < 40);
            Pw_Result_oth    = 5'($urandom_range(0, 7));
            Result_oth       = 16'($urandom);
            freeze_back      = ($urandom_range(0, 99) < 10);
            flush            = ($urandom_range(0, 99) < 2);
            tick();
            if (n == 700) do_reset();
        end
        idle(); tick(); tick();
        @(negedge clk); #1;
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
